// File: rtl/counter_port_pkg.sv
// Shared types and constants for the parallel counter-port initiator.
// BUS_IN_REG_EN adds one input register stage, which shifts the expected read-back by one.
package counter_port_pkg;

  localparam int W_DEFAULT = 41;
  localparam int PIN_OE_N  = 41;
  localparam int PIN_WE_N  = 42;

`ifdef BUS_IN_REG_EN
  localparam int EXP_OFFSET = 3;
`else
  localparam int EXP_OFFSET = 2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TURN,
    WAIT,
    OE,
    SAMPLE,
    RELEASE,
    DONE
  } cp_state_e;

endpackage

// File: rtl/counter_port_initiator.sv
// Load/run/read-back/check initiator for the counter port; R+6 cycles LOAD..DONE (R+7 with BUS_IN_REG_EN).
// No backpressure: start is only sampled in IDLE, and starts arriving while busy are dropped.
module counter_port_initiator
  import counter_port_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  load_value,
  input  logic [CW-1:0] run_cycles,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  read_value,
  output logic [7:0]    fail_cnt,
  output logic [W-1:0]  bus_out,
  output logic          bus_oe,
  input  logic [W-1:0]  bus_in,
  output logic          we_n_o,
  output logic          oe_n_o
);

  cp_state_e     state_q, state_d;
  logic [W-1:0]  v_q;
  logic [CW-1:0] r_q;
  logic [CW-1:0] wait_q, wait_d;
  logic [W-1:0]  expected;
  logic [W-1:0]  cap_val;
  logic          cap_en;
  logic          match;
  logic          sample_last;

  assign expected = v_q + W'(r_q) + W'(EXP_OFFSET);

`ifdef BUS_IN_REG_EN
  logic [W-1:0] bus_in_q;
  logic         ext_q;

  // Second SAMPLE cycle lets the registered bus copy catch up; it is captured during RELEASE.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bus_in_q <= '0;
      ext_q    <= 1'b0;
    end else begin
      bus_in_q <= bus_in;
      ext_q    <= (state_q == SAMPLE) && !ext_q;
    end
  end

  assign sample_last = ext_q;
  assign cap_en      = (state_q == RELEASE);
  assign cap_val     = bus_in_q;
  assign match       = (bus_in_q == expected);
`else
  assign sample_last = 1'b1;
  assign cap_en      = (state_q == SAMPLE);
  assign cap_val     = bus_in;
  assign match       = (read_value == expected);
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = TURN;
      TURN: begin
        if (r_q == '0) begin
          state_d = OE;
        end else begin
          state_d = WAIT;
          wait_d  = r_q;
        end
      end
      WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == CW'(1)) state_d = OE;
      end
      OE:      state_d = SAMPLE;
      SAMPLE:  state_d = sample_last ? RELEASE : SAMPLE;
      RELEASE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad-side outputs are decoded from the next state so they are flop-driven in the state they belong to.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      v_q        <= '0;
      r_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      read_value <= '0;
      fail_cnt   <= '0;
      bus_out    <= '0;
      bus_oe     <= 1'b0;
      we_n_o     <= 1'b1;
      oe_n_o     <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((state_q == IDLE) && start) begin
        v_q <= load_value;
        r_q <= run_cycles;
      end
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      bus_oe  <= (state_d == LOAD);
      we_n_o  <= (state_d != LOAD);
      oe_n_o  <= !((state_d == OE) || (state_d == SAMPLE));
      bus_out <= (state_d == LOAD) ? load_value : '0;
      if (cap_en) read_value <= cap_val;
      if (state_q == RELEASE) begin
        pass <= match;
        if (!match && (fail_cnt != 8'hFF)) fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end

endmodule
